// File: rtl/afifo_pkg.sv
// Default geometry for the afifo block; the module exposes these as overridable parameters.
package afifo_pkg;
    localparam int AFIFO_WIDTH = 3;
    localparam int AFIFO_DEPTH = 8;
    localparam int AFIFO_AW    = 3;
endpackage

// File: rtl/afifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and combinational flags.
// rclk is a legacy port only; every register is clocked by wclk.
module afifo
    import afifo_pkg::*;
#(
    parameter int WIDTH = AFIFO_WIDTH,
    parameter int DEPTH = AFIFO_DEPTH,
    parameter int AW    = AFIFO_AW
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             rclk,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_write;
    logic             do_read;
    logic             unused_rclk;

    assign unused_rclk = rclk;

    // Pointer / flag block: equal pointers mean empty, differing wrap bits with equal addresses mean full.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_write = wen && !full;
    assign do_read  = ren && !empty;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) wptr <= wptr + PTR_ONE;
            if (do_read)  rptr <= rptr + PTR_ONE;
        end
    end

    // Memory write block: contents are not reset, pointers alone define what is valid.
    always_ff @(posedge wclk) begin
        if (do_write) mem[wptr[AW-1:0]] <= datain;
    end

    // Registered read block.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            dataout <= '0;
        end else if (do_read) begin
            dataout <= mem[rptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_afifo.sv
// Directed self-checking bench for afifo: reset, fill/drain, underflow, wrap with concurrent access, rclk independence.
module tb_afifo;
    logic       wclk;
    logic       rst;
    logic       rclk;
    logic       wen;
    logic       ren;
    logic [2:0] datain;
    logic [2:0] dataout;
    logic       full;
    logic       empty;
    logic       rclk_run;

    int pass_cnt;
    int total_cnt;

    logic [2:0] fill_vals [8];
    logic [2:0] wrap_vals [6];

    afifo #(.WIDTH(3), .DEPTH(8), .AW(3)) dut (
        .wclk    (wclk),
        .rst     (rst),
        .rclk    (rclk),
        .wen     (wen),
        .ren     (ren),
        .datain  (datain),
        .dataout (dataout),
        .full    (full),
        .empty   (empty)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial rclk = 1'b0;
    always begin
        #8;
        if (rclk_run) rclk = ~rclk;
    end

    // One wclk edge with the given request; outputs are stable 1 ns later.
    task automatic cycle(input logic w, input logic r, input logic [2:0] d);
        wen    = w;
        ren    = r;
        datain = d;
        @(posedge wclk);
        #1;
        wen    = 1'b0;
        ren    = 1'b0;
        datain = 3'd0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #20;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #20;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
        total_cnt++;
        if (dataout !== 3'd0) $display("FAIL reset_dataout: got %0d want 0", dataout); else pass_cnt++;
        rst = 1'b0;
        // Fill part way, read once so dataout is non-zero, then reset between edges.
        cycle(1'b1, 1'b0, 3'd6);
        cycle(1'b1, 1'b0, 3'd2);
        cycle(1'b1, 1'b0, 3'd3);
        cycle(1'b0, 1'b1, 3'd0);
        total_cnt++;
        if (dataout !== 3'd6) $display("FAIL midfill_read: got %0d want 6", dataout); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL async_rst_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++;
        if (full !== 1'b0) $display("FAIL async_rst_full: got %b want 0", full); else pass_cnt++;
        total_cnt++;
        if (dataout !== 3'd0) $display("FAIL async_rst_dataout: got %0d want 0", dataout); else pass_cnt++;
        #9;
        rst = 1'b0;
        // First edge after release must accept a write; stale contents are gone.
        cycle(1'b1, 1'b0, 3'd5);
        total_cnt++;
        if (empty !== 1'b0) $display("FAIL first_write_after_rst: empty got %b want 0", empty); else pass_cnt++;
        cycle(1'b0, 1'b1, 3'd0);
        total_cnt++;
        if (dataout !== 3'd5) $display("FAIL first_read_after_rst: got %0d want 5", dataout); else pass_cnt++;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL first_read_after_rst_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_fill_drain(input string tag);
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, fill_vals[i]);
            total_cnt++;
            if (full !== (i == 7)) $display("FAIL %s_fill_full[%0d]: got %b want %b", tag, i, full, (i == 7));
            else pass_cnt++;
        end
        cycle(1'b1, 1'b0, 3'd5);
        total_cnt++;
        if (full !== 1'b1) $display("FAIL %s_overflow_full: got %b want 1", tag, full); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 3'd0);
            total_cnt++;
            if (dataout !== fill_vals[i]) $display("FAIL %s_drain_data[%0d]: got %0d want %0d", tag, i, dataout, fill_vals[i]);
            else pass_cnt++;
            total_cnt++;
            if (empty !== (i == 7)) $display("FAIL %s_drain_empty[%0d]: got %b want %b", tag, i, empty, (i == 7));
            else pass_cnt++;
        end
        total_cnt++;
        if (full !== 1'b0) $display("FAIL %s_drain_full: got %b want 0", tag, full); else pass_cnt++;
    endtask

    task automatic test_underflow();
        // Continues from a drained FIFO whose last output was 0.
        cycle(1'b0, 1'b1, 3'd0);
        total_cnt++;
        if (dataout !== 3'd0) $display("FAIL underflow_hold: got %0d want 0", dataout); else pass_cnt++;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL underflow_empty: got %b want 1", empty); else pass_cnt++;
        // Non-zero last value must also hold.
        cycle(1'b1, 1'b0, 3'd3);
        cycle(1'b0, 1'b1, 3'd0);
        cycle(1'b0, 1'b1, 3'd0);
        cycle(1'b0, 1'b0, 3'd0);
        total_cnt++;
        if (dataout !== 3'd3) $display("FAIL underflow_hold3: got %0d want 3", dataout); else pass_cnt++;
    endtask

    task automatic test_simul_empty();
        apply_reset();
        cycle(1'b1, 1'b1, 3'd4);
        total_cnt++;
        if (empty !== 1'b0) $display("FAIL simul_empty_write: empty got %b want 0", empty); else pass_cnt++;
        total_cnt++;
        if (dataout !== 3'd0) $display("FAIL simul_empty_noread: got %0d want 0", dataout); else pass_cnt++;
        cycle(1'b0, 1'b1, 3'd0);
        total_cnt++;
        if (dataout !== 3'd4) $display("FAIL simul_empty_readback: got %0d want 4", dataout); else pass_cnt++;
    endtask

    task automatic test_simul_full();
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'(7 - i));
        cycle(1'b1, 1'b1, 3'd3);
        total_cnt++;
        if (dataout !== 3'd7) $display("FAIL simul_full_read: got %0d want 7", dataout); else pass_cnt++;
        total_cnt++;
        if (full !== 1'b0) $display("FAIL simul_full_flag: got %b want 0", full); else pass_cnt++;
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 1'b1, 3'd0);
            total_cnt++;
            if (dataout !== 3'(7 - i)) $display("FAIL simul_full_drain[%0d]: got %0d want %0d", i, dataout, 7 - i);
            else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL simul_full_dropped_write: empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_wrap_simul();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 3'(i + 1));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 3'd0);
            total_cnt++;
            if (dataout !== 3'(i + 1)) $display("FAIL wrap_pre_read[%0d]: got %0d want %0d", i, dataout, i + 1);
            else pass_cnt++;
        end
        cycle(1'b1, 1'b0, wrap_vals[0]);
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, 1'b1, wrap_vals[i]);
            total_cnt++;
            if (dataout !== wrap_vals[i-1]) $display("FAIL wrap_simul_data[%0d]: got %0d want %0d", i, dataout, wrap_vals[i-1]);
            else pass_cnt++;
            total_cnt++;
            if (full !== 1'b0 || empty !== 1'b0) $display("FAIL wrap_simul_flags[%0d]: got full=%b empty=%b want 0 0", i, full, empty);
            else pass_cnt++;
        end
        cycle(1'b0, 1'b1, 3'd0);
        total_cnt++;
        if (dataout !== wrap_vals[5]) $display("FAIL wrap_last_data: got %0d want %0d", dataout, wrap_vals[5]); else pass_cnt++;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL wrap_last_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rclk_run  = 1'b0;
        wen       = 1'b0;
        ren       = 1'b0;
        datain    = 3'd0;
        rst       = 1'b1;
        fill_vals = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        wrap_vals = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        @(posedge wclk);
        #1;
        test_reset();
        test_fill_drain("fill");
        test_underflow();
        test_simul_empty();
        test_simul_full();
        test_wrap_simul();
        rclk_run = 1'b1;
        test_fill_drain("rclk");
        test_wrap_simul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/afifo.md
AFIFO -- requirements
Module: Afifo

Interface
REQ-001 Parameter: WIDTH, 3, data word width in bits.
REQ-002 Parameter: DEPTH, 8, number of storage entries; power of two.
REQ-003 Parameter: AW, 3, address width; SHALL equal log2(DEPTH).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 wclk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 rclk  input  1  kept for port compatibility only; SHALL have no functional effect.
REQ-008 wen  input  1  write request.
REQ-009 ren  input  1  read request.
REQ-010 datain  input  WIDTH  write data.
REQ-011 dataout  output  WIDTH  registered read data.
REQ-012 full  output  1  high when DEPTH entries are stored.
REQ-013 empty  output  1  high when zero entries are stored.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH register array.
REQ-015 Write and read pointers SHALL each be AW+1 bits wide: AW address bits plus one wrap bit.
REQ-016 Write: if wen=1 and full=0 at a wclk rising edge, mem[wptr[AW-1:0]] SHALL be loaded with datain, and wptr SHALL increment modulo 2^(AW+1).
REQ-017 Write when full: if wen=1 and full=1, the write SHALL be dropped, leaving memory and wptr unchanged.
REQ-018 Read: if ren=1 and empty=0 at a wclk rising edge, dataout SHALL be loaded with mem[rptr[AW-1:0]], and rptr SHALL increment. Read latency is one clock.
REQ-019 Read when empty: if ren=1 and empty=1, the read SHALL be ignored, and dataout and rptr SHALL hold.
REQ-020 dataout SHALL hold its last value whenever no read occurs.
REQ-021 empty SHALL be combinational from the registered pointers: empty = (wptr == rptr).
REQ-022 full SHALL be combinational from the registered pointers: full = (wrap bits differ) AND (address bits equal).
REQ-023 Simultaneous wen and ren with the FIFO neither full nor empty: both operations SHALL occur in the same cycle, and the occupancy SHALL be unchanged.
REQ-024 Simultaneous wen and ren while empty=1: only the write SHALL occur.
REQ-025 Simultaneous wen and ren while full=1: only the read SHALL occur.
REQ-026 Pointer wrap-around from DEPTH-1 to 0 SHALL toggle the wrap bit and preserve FIFO ordering.
REQ-027 Data SHALL leave the FIFO in exactly the order it was accepted.
REQ-028 No X-propagation: dataout SHALL be 0 until the first successful read.

Reset
REQ-029 While rst=1: wptr=0, rptr=0, dataout=0, which yields empty=1 and full=0.
REQ-030 Reset SHALL take effect immediately, independent of wclk, including mid-operation, discarding all stored contents.
REQ-031 Memory array contents need not be cleared by reset.
REQ-032 The first write SHALL be accepted on the first wclk rising edge after rst is deasserted.

Structure
REQ-033 WIDTH, DEPTH and AW SHALL be module parameters; no shared package is required.
REQ-034 No sub-module SHALL be used; the design is a single flat module.
REQ-035 The design SHALL contain three parts: a pointer/flag block, a memory write block, and a registered read block.

Verification
REQ-036 Reset check: rst=1 for 20 ns -> empty=1, full=0, dataout=0; asserting rst again mid-fill SHALL immediately return empty=1 and full=0.
REQ-037 Fill: write 1,2,3,4,5,6,7,0 -> full=1 after the 8th edge; a 9th write of 5 SHALL be dropped, leaving full=1.
REQ-038 Drain: 8 reads after the fill -> dataout SHALL be 1,2,3,4,5,6,7,0 in order, one clock after each read edge; empty=1 after the 8th read.
REQ-039 Underflow: a read while empty -> dataout SHALL hold 0 (the last value), and empty SHALL stay 1.
REQ-040 Wrap and simultaneous: write 5 values and read 5, then write 6 values while reading concurrently from the 2nd write onward -> ordering SHALL be preserved across the pointer wrap, and full SHALL never assert.
REQ-041 rclk toggling: with rclk running at 16 ns period against wclk at 10 ns -> behaviour SHALL be identical to rclk held at 0.
